// File: rtl/slc3_mem_pkg.sv
// slc3_mem_pkg: shared FSM state type and wait-counter sizing for the SLC-3 memory controller
package slc3_mem_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, RD, WR, DONE} mem_state_t;
    function automatic int cnt_width(input int ws);
        return (ws < 1) ? 1 : $clog2(ws + 1);
    endfunction
endpackage

// File: rtl/slc3_io_regs.sv
// slc3_io_regs: I/O window decode, hex/LED registers and I/O read-data mux
module slc3_io_regs #(
    parameter int DATA_W = 16,
    parameter int CPU_ADDR_W = 16,
    parameter int NUM_HEX = 4,
    parameter int LED_W = 12,
    parameter logic [CPU_ADDR_W-1:0] SW_ADDR = 16'hFFFF,
    parameter logic [CPU_ADDR_W-1:0] LED_ADDR = 16'hFFFE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [CPU_ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W-1:0]     switches,
    output logic                  hit,
    output logic [DATA_W-1:0]     rdata,
    output logic [4*NUM_HEX-1:0]  hex_val,
    output logic [LED_W-1:0]      led
);
    logic sw_hit, led_hit;
    assign sw_hit = addr == SW_ADDR;
    assign led_hit = addr == LED_ADDR;
    assign hit = sw_hit || led_hit;
    assign rdata = sw_hit ? switches : DATA_W'(led);
    always_ff @(posedge clk) begin
        if (rst) begin
            hex_val <= '0;
            led <= '0;
        end else begin
            if (wr && sw_hit) hex_val <= wdata[4*NUM_HEX-1:0];
            if (wr && led_hit) led <= wdata[LED_W-1:0];
        end
    end
endmodule

// File: rtl/slc3_mem_ctrl.sv
// slc3_mem_ctrl: req/ack memory controller for the SLC-3 with wait-stated async SRAM and I/O window
module slc3_mem_ctrl
    import slc3_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CPU_ADDR_W = 16,
    parameter int SRAM_ADDR_W = 20,
    parameter int WAIT_STATES = 1,
    parameter int NUM_HEX = 4,
    parameter int LED_W = 12,
    parameter logic [CPU_ADDR_W-1:0] SW_ADDR = 16'hFFFF,
    parameter logic [CPU_ADDR_W-1:0] LED_ADDR = 16'hFFFE
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [CPU_ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]      cpu_wdata,
    output logic [DATA_W-1:0]      cpu_rdata,
    output logic                   cpu_ack,
    input  logic [DATA_W-1:0]      switches,
    output logic [4*NUM_HEX-1:0]   hex_val,
    output logic [LED_W-1:0]       led,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n,
    output logic [DATA_W-1:0]      sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [DATA_W-1:0]      sram_dq_in
);
    localparam int CW = cnt_width(WAIT_STATES);
    localparam logic [CW-1:0] WS = CW'(WAIT_STATES);
    mem_state_t state, next;
    logic [CW-1:0] cnt;
    logic was_wr, io_hit, accept, hold, ce;
    logic [DATA_W-1:0] io_rdata;
    assign accept = state == IDLE && cpu_req;
    slc3_io_regs #(
        .DATA_W(DATA_W), .CPU_ADDR_W(CPU_ADDR_W), .NUM_HEX(NUM_HEX), .LED_W(LED_W),
        .SW_ADDR(SW_ADDR), .LED_ADDR(LED_ADDR)
    ) u_io (
        .clk(Clk), .rst(Reset), .wr(accept && cpu_we), .addr(cpu_addr), .wdata(cpu_wdata),
        .switches(switches), .hit(io_hit), .rdata(io_rdata), .hex_val(hex_val), .led(led)
    );
    always_comb begin
        next = state;
        case (state)
            IDLE:    if (cpu_req) next = io_hit ? DONE : cpu_we ? SETUP : RD;
            SETUP:   next = WR;
            RD, WR:  if (cnt == '0) next = DONE;
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt <= '0;
            was_wr <= 1'b0;
            cpu_rdata <= '0;
            sram_addr <= '0;
            sram_dq_out <= '0;
        end else begin
            state <= next;
            if (accept) begin
                was_wr <= cpu_we && !io_hit;
                sram_addr <= SRAM_ADDR_W'(cpu_addr);
                sram_dq_out <= cpu_wdata;
            end
            if ((accept && !io_hit) || state == SETUP) cnt <= WS;
            else if ((state == RD || state == WR) && cnt != '0) cnt <= cnt - 1'b1;
            if (accept && io_hit && !cpu_we) cpu_rdata <= io_rdata;
            else if (state == RD && cnt == '0) cpu_rdata <= sram_dq_in;
        end
    end
    // DONE after an SRAM write keeps the bus driven and the chip selected as data hold
    assign hold = state == DONE && was_wr;
    assign ce = state == SETUP || state == RD || state == WR || hold;
    assign cpu_ack = state == DONE;
    assign sram_ce_n = !ce;
    assign sram_ub_n = !ce;
    assign sram_lb_n = !ce;
    assign sram_oe_n = state != RD;
    assign sram_we_n = state != WR;
    assign sram_dq_oe = state == SETUP || state == WR || hold;
endmodule

// File: doc/slc3_mem_ctrl.md
# slc3_mem_ctrl

Parametrised memory and I/O controller for the SLC-3. It sits between the CPU's MAR/MDR datapath and the external asynchronous SRAM, and replaces the fixed-timing memory interface with a request/acknowledge handshake. SRAM access timing is set by a configurable wait-state count. Addresses in the I/O window are decoded to switch, hex-display and LED registers.

## Interface
Parameters:
- `DATA_W`, 16: CPU and SRAM data width.
- `CPU_ADDR_W`, 16: CPU address width.
- `SRAM_ADDR_W`, 20: SRAM address width; must be ≥ `CPU_ADDR_W`.
- `WAIT_STATES`, 1: extra cycles the SRAM strobes are held beyond the minimum; must be ≥ 0.
- `NUM_HEX`, 4: number of hex digits; `4*NUM_HEX` must be ≤ `DATA_W`.
- `LED_W`, 12: LED register width; must be ≤ `DATA_W`.
- `SW_ADDR`, 16'hFFFF: I/O address. Reads return the switches; writes load the hex register.
- `LED_ADDR`, 16'hFFFE: I/O address for the LED register (read/write).

Ports:
- `Clk`  in  1  sole clock; all state changes on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  transaction request; held high until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read; stable while `cpu_req` is high.
- `cpu_addr`  in  `CPU_ADDR_W`  word address.
- `cpu_wdata`  in  `DATA_W`  write data (drives MDR path).
- `cpu_rdata`  out  `DATA_W`  registered read data; valid when `cpu_ack` = 1.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `switches`  in  `DATA_W`  board switches; sampled only on an I/O read.
- `hex_val`  out  `4*NUM_HEX`  hex display nibbles; digit 0 is in the LSBs.
- `led`  out  `LED_W`  LED register.
- `sram_addr`  out  `SRAM_ADDR_W`  `cpu_addr` zero-extended.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_ub_n`, `sram_lb_n`  out  1 each  active-low SRAM strobes.
- `sram_dq_out`  out  `DATA_W`  write data to the external tristate buffer.
- `sram_dq_oe`  out  1  1 = controller drives the SRAM bus.
- `sram_dq_in`  in  `DATA_W`  data read from the SRAM bus.

## Operation
- States are IDLE, SETUP, RD, WR and DONE.
- All SRAM strobes and `sram_dq_oe` are decoded from the state register only.
  - `ce_n`, `ub_n` and `lb_n` are low in SETUP, RD, WR and DONE-after-write.
  - `oe_n` is low only in RD.
  - `we_n` is low only in WR.
  - `dq_oe` is high in SETUP, WR and DONE-after-write.
- An I/O hit is `cpu_addr` == `SW_ADDR` or `cpu_addr` == `LED_ADDR`. Every other address goes to the SRAM.
- IDLE with `cpu_req`=1:
  - I/O read: `cpu_rdata` ← switches, or ← LED register zero-extended. Next state is DONE.
  - I/O write: hex register ← `cpu_wdata[4*NUM_HEX-1:0]`, or LED register ← `cpu_wdata[LED_W-1:0]`. Next state is DONE.
  - SRAM read: next state is RD; the wait counter is loaded with `WAIT_STATES`.
  - SRAM write: next state is SETUP.
- RD counts down. On the edge where the count is 0, `cpu_rdata` ← `sram_dq_in` and the next state is DONE.
- SETUP always lasts 1 cycle, then goes to WR with the counter loaded.
- WR counts down; at count 0 the next state is DONE.
- DONE:
  - `cpu_ack` = 1 for this one cycle.
  - After a write, `dq_oe` stays high and `ce_n` stays low as data hold.
  - The next state is always IDLE. `cpu_req` is not sampled in DONE.
- `sram_addr` and `sram_dq_out` are registered at request acceptance and held until the return to IDLE.
- Protocol violations:
  - If `cpu_req` drops mid-transaction, the transaction still completes and acks.
  - Changes to `cpu_addr`, `cpu_we` or `cpu_wdata` after acceptance are ignored.
- Reset mid-transaction:
  - The state returns to IDLE on the reset edge and the transaction is lost with no ack.
  - I/O registers clear, even during an I/O write.

## Timing
- Reset values:
  - state IDLE; `cpu_ack` 0; `cpu_rdata` 0; `hex_val` 0; `led` 0.
  - All `_n` strobes 1; `sram_dq_oe` 0; `sram_addr` 0; `sram_dq_out` 0.
- Latency, counting the cycle in which `cpu_req` is first sampled in IDLE as cycle 0:
  - I/O access: ack in cycle 1.
  - SRAM read: RD occupies cycles 1 to W+1; ack in cycle W+2.
  - SRAM write: SETUP in cycle 1; WR in cycles 2 to W+2; ack in cycle W+3.
- Throughput: at least one IDLE cycle separates transactions. A request that is still high in the IDLE cycle after DONE starts a new transaction.
- Write hold: `we_n` rises one cycle before `dq_oe` falls and before the address changes. Address and data are stable for all of SETUP, WR and DONE.

## Structure
- Package `slc3_mem_pkg` holds:
  - the state enum `mem_state_t`;
  - a function computing the counter width, `$clog2(WAIT_STATES+1)`, with a minimum of 1.
- Sub-module `slc3_io_regs` holds:
  - the hex and LED registers;
  - the address decode and the read-data mux.
  The FSM, counter and SRAM strobes stay in the top module.

## Test plan
- `WAIT_STATES`=1, SRAM read of 16'h0040 with `sram_dq_in`=16'hA5A5:
  - `oe_n` low in cycles 1–2;
  - `cpu_ack` in cycle 3 with `cpu_rdata`=16'hA5A5.
- `WAIT_STATES`=1, SRAM write of 16'h1234 to 16'h0010:
  - SETUP in cycle 1;
  - `we_n` low in cycles 2–3;
  - ack in cycle 4;
  - `dq_oe` high in cycles 1–4;
  - `sram_addr`=20'h00010 throughout.
- I/O write of 16'hBEEF to `SW_ADDR`:
  - ack in cycle 1;
  - `hex_val`=16'hBEEF;
  - every SRAM strobe stays high.
- I/O read with `switches`=16'h00C3, then LED write of 16'hFFFF then LED read:
  - switch read returns 16'h00C3;
  - `led`=12'hFFF;
  - LED read returns 16'h0FFF.
- `WAIT_STATES`=0 read and write:
  - read acks in cycle 2;
  - write acks in cycle 3;
  - no FSM dead cycles.
- Reset asserted in cycle 2 of a `WAIT_STATES`=3 write:
  - next cycle: IDLE, `we_n`=1, `dq_oe`=0;
  - no ack ever issued;
  - a subsequent read completes normally.
